// File: rtl/scan_decoder_pkg.sv
// Shared constants and helpers for the scan_decoder digit-select path.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2 that never returns less than 1, so a counter always has at least one bit.
    function automatic int safe_clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << bits) < 64'(value)) begin
                bits = bits + 1;
            end else begin
                bits = bits;
            end
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/scan_decoder_onehot.sv
// Combinational binary-to-one-hot decoder; the generalised form of the old 3-to-8.
module onehot_decoder #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] onehot
);

    localparam int N = 2 ** SEL_W;

    // Drive exactly one bit high at the selected position.
    always_comb begin
        onehot      = {N{1'b0}};
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct select or prescaled free-running scan,
// per-output blanking, selectable output polarity and a scan-advance strobe.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int PRESCALE   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel_in,
    input  logic [(2**SEL_W)-1:0]  blank_mask,
    output logic [(2**SEL_W)-1:0]  out,
    output logic [SEL_W-1:0]       idx,
    output logic                   tick
);

    localparam int N    = 2 ** SEL_W;
    localparam int PS_W = safe_clog2(PRESCALE);
    localparam logic [PS_W-1:0] PRE_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [N-1:0]    OUT_IDLE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    logic [SEL_W-1:0] idx_r;
    logic [PS_W-1:0]  pre_r;
    logic             tick_r;
    logic [N-1:0]     out_r;

    logic [SEL_W-1:0] idx_next_s;
    logic [PS_W-1:0]  pre_next_s;
    logic             tick_next_s;
    logic [N-1:0]     onehot_s;
    logic [N-1:0]     active_s;
    logic [N-1:0]     out_next_s;

    // Next-state selection: hold when disabled, follow sel_in in direct mode, count in scan mode.
    always_comb begin
        idx_next_s  = idx_r;
        pre_next_s  = pre_r;
        tick_next_s = 1'b0;
        if (!en) begin
            idx_next_s  = idx_r;
            pre_next_s  = pre_r;
            tick_next_s = 1'b0;
        end else if (mode == MODE_DIRECT) begin
            idx_next_s  = sel_in;
            pre_next_s  = {PS_W{1'b0}};
            tick_next_s = 1'b0;
        end else if (pre_r == PRE_MAX) begin
            idx_next_s  = idx_r + SEL_W'(1);
            pre_next_s  = {PS_W{1'b0}};
            tick_next_s = 1'b1;
        end else begin
            idx_next_s  = idx_r;
            pre_next_s  = pre_r + PS_W'(1);
            tick_next_s = 1'b0;
        end
    end

    onehot_decoder #(.SEL_W(SEL_W)) u_onehot (
        .sel    (idx_next_s),
        .onehot (onehot_s)
    );

    // Decode the upcoming index so out and idx update on the same edge.
    always_comb begin
        active_s = onehot_s & ~blank_mask & {N{en}};
        if (ACTIVE_LOW != 0) begin
            out_next_s = ~active_s;
        end else begin
            out_next_s = active_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r  <= {SEL_W{1'b0}};
            pre_r  <= {PS_W{1'b0}};
            tick_r <= 1'b0;
            out_r  <= OUT_IDLE;
        end else begin
            idx_r  <= idx_next_s;
            pre_r  <= pre_next_s;
            tick_r <= tick_next_s;
            out_r  <= out_next_s;
        end
    end

    assign out  = out_r;
    assign idx  = idx_r;
    assign tick = tick_r;

endmodule
